// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment vectors are ordered a..g with 'a' at index 0.
package seg_pkg;

  typedef logic [0:6] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b0000000;

  // Active-high a..g glyphs for 0-F; 'b' and 'd' are the lowercase shapes.
  localparam seg7_t HEX_SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational nibble to active-high a..g segment pattern.
module hex7seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg7_t      o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed 7-segment scan driver with tear-free frame loads,
// leading-zero blanking, PWM dimming and a per-slot anti-ghosting dead cycle.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BRIGHT_W       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [0:7]              seg,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic                    frame_tick
);

  localparam int PW = width_of(REFRESH_DIV);
  localparam int IW = width_of(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [0:7] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  if (REFRESH_DIV < 4) begin : g_bad_div
    $error("seg_scan_driver: REFRESH_DIV must be >= 4");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_driver: NUM_DIGITS must be in 1..8");
  end

  logic [PW-1:0]         r_pcnt;
  logic [IW-1:0]         r_idx;
  logic [BRIGHT_W-1:0]   r_pwm;
  logic [VW-1:0]         r_shadow_val;
  logic [NUM_DIGITS-1:0] r_shadow_dp;
  logic [VW-1:0]         r_disp_val;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic                  r_pending;
  logic [0:7]            r_seg;
  logic [NUM_DIGITS-1:0] r_digit;
  logic                  r_frame_tick;

  logic                  w_slot_end;
  logic                  w_boundary;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic                  w_lz;
  logic                  w_zero_run;
  seg7_t                 w_glyph;
  logic [0:7]            w_seg_next;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_dig_on;

  assign w_slot_end = (r_pcnt == PCNT_LAST);
  assign w_boundary = w_slot_end && (r_idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_idx  <= '0;
      r_pwm  <= '0;
    end else begin
      r_pcnt <= w_slot_end ? '0 : r_pcnt + 1'b1;
      if (w_slot_end) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      r_pwm <= (r_pwm == {BRIGHT_W{1'b1}}) ? '0 : r_pwm + 1'b1;
    end
  end

  // A load on the boundary cycle bypasses the shadow so it is never a frame late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_in;
      end
      if (w_boundary) begin
        if (load) begin
          r_disp_val <= value;
          r_disp_dp  <= dp_in;
        end else if (r_pending) begin
          r_disp_val <= r_shadow_val;
          r_disp_dp  <= r_shadow_dp;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Scan from the top nibble down so the zero run covers "this and all higher".
  always_comb begin
    w_nib      = 4'd0;
    w_dp       = 1'b0;
    w_lz       = 1'b0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (r_disp_val[4*i +: 4] == 4'd0);
      if (r_idx == IW'(i)) begin
        w_nib = r_disp_val[4*i +: 4];
        w_dp  = r_disp_dp[i];
        w_lz  = w_zero_run && (i != 0);
      end
    end
  end

  hex7seg_decoder u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_glyph)
  );

  assign w_seg_next = {(blank_lz && w_lz) ? SEG_BLANK : w_glyph, w_dp};
  assign w_lit      = (&brightness) || (r_pwm < brightness);

  always_comb begin
    w_dig_on = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_dig_on[i] = (r_idx == IW'(i)) && (r_pcnt != '0) && w_lit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= SEG_OFF;
      r_digit      <= DIG_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_next : w_seg_next;
      r_digit      <= (DIG_ACTIVE_LOW != 0) ? ~w_dig_on : w_dig_on;
      r_frame_tick <= w_boundary;
    end
  end

  assign seg        = r_seg;
  assign digit      = r_digit;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: 4 digits, 4-cycle slots, 2-bit brightness, active-low.
// A frame-level model predicts every output cycle; tables pin down known glyphs.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BW = 2;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          blank_lz;
  logic [BW-1:0] brightness;
  logic [0:7]    seg;
  logic [3:0]    digit;
  logic          frame_tick;

  seg_scan_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .BRIGHT_W       (BW),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .seg        (seg),
    .digit      (digit),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          t;
  logic [15:0] lat_val, shown_val;
  logic [3:0]  lat_dp, shown_dp;
  logic [0:7]  obs_seg;
  logic [3:0]  obs_digit;
  logic        obs_ft;
  logic [12:0] exp_q[$];

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        blz;
    logic [31:0] segs;  // {digit3, digit2, digit1, digit0} active-low seg bytes
  } vec_t;

  vec_t vecs[6];

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011;  10: return 7'b1110111; 11: return 7'b0011111;
      12: return 7'b1001110; 13: return 7'b0111101; 14: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    lat_val = '0; lat_dp = '0; shown_val = '0; shown_dp = '0;
    exp_q.delete();
  endtask

  // Called at a negedge with inputs set; predicts, clocks once, compares.
  task automatic step();
    int idx, pc, pwm, nib;
    logic [0:7]  es;
    logic [3:0]  ed;
    logic        on;
    logic [12:0] e;
    pc  = t % RD;
    idx = (t / RD) % ND;
    pwm = t % (1 << BW);
    nib = int'((shown_val >> (4 * idx)) & 16'hF);
    if (blank_lz && idx > 0 && (shown_val >> (4 * idx)) == 16'd0)
      es = {7'b0000000, shown_dp[idx]};
    else
      es = {glyph(nib), shown_dp[idx]};
    es = ~es;
    on = (pc != 0) && (brightness == 2'b11 || pwm < int'(brightness));
    ed = 4'hF;
    if (on) ed[idx] = 1'b0;
    exp_q.push_back({es, ed, (t % FRAME) == FRAME - 1});
    if (load) begin lat_val = value; lat_dp = dp_in; end
    if ((t % FRAME) == FRAME - 1) begin shown_val = lat_val; shown_dp = lat_dp; end
    t++;
    @(posedge clk);
    @(negedge clk);
    obs_seg = seg; obs_digit = digit; obs_ft = frame_tick;
    e = exp_q.pop_front();
    check("seg", 32'(obs_seg), 32'(e[12:5]));
    check("digit", 32'(obs_digit), 32'(e[4:1]));
    check("frame_tick", 32'(obs_ft), 32'(e[0]));
  endtask

  task automatic run_to(input int phase);
    for (int k = 0; k < FRAME + 1 && (t % FRAME) != phase; k++) step();
  endtask

  // Steps through one whole frame from its start, checking each digit's glyph.
  task automatic show_frame(input logic [31:0] segs, input string tag);
    run_to(0);
    for (int j = 0; j < FRAME; j++) begin
      step();
      if ((j % RD) == 1) check(tag, 32'(obs_seg), 32'(segs[8 * (j / RD) +: 8]));
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}};
    vecs[1] = '{16'h0070, 4'b1000, 1'b1, {8'hFE, 8'hFF, 8'h1F, 8'h03}};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
    vecs[3] = '{16'hABCD, 4'b0000, 1'b0, {8'h11, 8'hC1, 8'h63, 8'h85}};
    vecs[4] = '{16'h0070, 4'b0000, 1'b0, {8'h03, 8'h03, 8'h1F, 8'h03}};
    vecs[5] = '{16'h0001, 4'b0001, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h9E}};

    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0; brightness = 2'b11;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Async reset while digit 3 is lit and frame_tick is high.
    run_to(FRAME - 1);
    step();
    #2 rst = 1'b1;
    #1;
    check("rst_digit", 32'(digit), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h000000FF);
    check("rst_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n = 0;
    obs_ft = 1'b0;
    while (!obs_ft && n < 40) begin step(); n++; end
    check("first_tick_cycle", 32'(n), 32'd16);

    // Old value must persist until the frame boundary after a mid-frame load.
    run_to(2 * RD);
    value = 16'h1234; load = 1'b1; step(); load = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("no_tear", 32'(obs_seg), 32'h03);

    for (int v = 0; v < 6; v++) begin
      value = vecs[v].val; dp_in = vecs[v].dp; blank_lz = vecs[v].blz;
      for (int k = 0; k < int'($urandom_range(0, FRAME - 1)); k++) step();
      load = 1'b1; step(); load = 1'b0;
      show_frame(vecs[v].segs, $sformatf("vec%0d_seg", v));
    end

    blank_lz = 1'b0; dp_in = '0;
    value = 16'h1234; load = 1'b1; step(); load = 1'b0;
    run_to(FRAME - 1);
    value = 16'hABCD; load = 1'b1; step(); load = 1'b0;
    show_frame({8'h11, 8'hC1, 8'h63, 8'h85}, "boundary_load");

    run_to(5);
    value = 16'h1111; load = 1'b1; step();
    value = 16'h2222; step(); load = 1'b0;
    show_frame({8'h25, 8'h25, 8'h25, 8'h25}, "last_load_wins");
    show_frame({8'h25, 8'h25, 8'h25, 8'h25}, "hold_after_load");

    brightness = 2'b00;
    run_to(0);
    for (int j = 0; j < FRAME; j++) begin
      step();
      check("bright0_off", 32'(obs_digit), 32'hF);
    end
    brightness = 2'b01;
    for (int j = 0; j < FRAME; j++) step();
    brightness = 2'b10;
    for (int j = 0; j < FRAME; j++) step();

    for (int k = 0; k < 400; k++) begin
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 1) == 0) value = value & 16'h00F0;
      blank_lz = 1'($urandom);
      brightness = 2'($urandom);
      step();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
